// File: rtl/pdm_cic_decimator_if.sv
// -----------------------------------------------------------------------------
// pdm_cic_decimator_if
// Groups the PDM sample-side and PCM result-side signals of one decimator
// channel into a single bundle.
//   PDM_EN    : one-cycle PDM bit strobe (driven by the PDM front end)
//   pdm_in    : PDM data bit, meaningful only while PDM_EN is high
//   cic_out   : 17-bit signed decimated sample, held between strobes
//   cic_valid : one-cycle pulse when cic_out updates
//   cic_sat   : one-cycle pulse, coincident with cic_valid, when clamped
// master = PDM source / PCM consumer side, slave = the decimator itself.
// -----------------------------------------------------------------------------
interface pdm_cic_decimator_if;
  logic               PDM_EN;
  logic               pdm_in;
  logic signed [16:0] cic_out;
  logic               cic_valid;
  logic               cic_sat;

  modport master (
    output PDM_EN,
    output pdm_in,
    input  cic_out,
    input  cic_valid,
    input  cic_sat
  );

  modport slave (
    input  PDM_EN,
    input  pdm_in,
    output cic_out,
    output cic_valid,
    output cic_sat
  );
endinterface

// File: rtl/pdm_cic_decimator.sv
// -----------------------------------------------------------------------------
// pdm_cic_decimator
// 4-stage Hogenauer CIC decimator for one PDM microphone channel. Converts the
// 1-bit PDM stream into 17-bit signed PCM at 1/2^DEC_LOG2 of the PDM bit rate.
// Ports:
//   PDMCLK : the only clock, all state changes on its rising edge
//   RST    : synchronous active-high reset (clears every register)
//   bus    : slave side of pdm_cic_decimator_if (PDM_EN, pdm_in in;
//            cic_out, cic_valid, cic_sat out, all outputs registered)
// Parameter:
//   DEC_LOG2 : log2 of the decimation ratio R, legal range 3..8
// -----------------------------------------------------------------------------
module pdm_cic_decimator #(
  parameter int DEC_LOG2 = 5
) (
  input  logic              PDMCLK,
  input  logic              RST,
  pdm_cic_decimator_if.slave bus
);

  localparam int N         = 4;
  // Full-scale R^N plus sign needs N*DEC_LOG2+2 bits; wrap beyond that is
  // harmless because the combs take differences modulo 2^W.
  localparam int W         = N * DEC_LOG2 + 2;
  // Small ratios would need a left shift to reach 17 bits; they are left
  // unscaled instead, so the shift never goes negative.
  localparam int SHIFT_RAW = N * DEC_LOG2 + 1 - 17;
  localparam int SHIFT     = (SHIFT_RAW > 0) ? SHIFT_RAW : 0;
  // Scaled value is held wide enough to see an overflow of the 17-bit range.
  localparam int YW        = (W > 18) ? W : 18;

  localparam logic [DEC_LOG2-1:0] CNT_LAST = {DEC_LOG2{1'b1}};
  localparam logic signed [YW-1:0] POS_LIM = YW'(18'sd65535);
  localparam logic signed [YW-1:0] NEG_LIM = YW'(-18'sd65536);

  logic signed [W-1:0]  integ_r [N];
  logic [DEC_LOG2-1:0]  cnt_r;
  logic signed [W-1:0]  comb_in_r;
  logic                 comb_in_vld_r;
  logic signed [W-1:0]  comb_r [N];
  logic signed [W-1:0]  dly_r [N];
  logic [N-1:0]         comb_vld_r;
  logic signed [16:0]   out_r;
  logic                 valid_r;
  logic                 sat_r;

  logic signed [W-1:0]  x_s;
  logic                 dec_evt_s;
  logic signed [YW-1:0] scaled_s;
  logic signed [16:0]   y_s;
  logic                 clamp_s;

  // Map the PDM bit to +1/-1 and detect the decimation event.
  always_comb begin
    x_s       = bus.pdm_in ? W'(2'sb01) : W'(2'sb11);
    dec_evt_s = bus.PDM_EN && (cnt_r == CNT_LAST);
  end

  // Integrator cascade, decimation counter and comb input latch.
  always_ff @(posedge PDMCLK) begin
    if (RST) begin
      for (int k = 0; k < N; k++) begin
        integ_r[k] <= '0;
      end
      cnt_r         <= '0;
      comb_in_r     <= '0;
      comb_in_vld_r <= 1'b0;
    end else begin
      comb_in_vld_r <= dec_evt_s;
      if (bus.PDM_EN) begin
        integ_r[0] <= integ_r[0] + x_s;
        // Each stage accumulates the previous stage's pre-update value.
        for (int k = 1; k < N; k++) begin
          integ_r[k] <= integ_r[k] + integ_r[k-1];
        end
        // Counter is exactly DEC_LOG2 bits wide, so R-1 wraps to 0 by itself.
        cnt_r <= cnt_r + 1'b1;
        if (dec_evt_s) begin
          // Post-update value of the last integrator.
          comb_in_r <= integ_r[N-1] + integ_r[N-2];
        end
      end
    end
  end

  // Comb pipeline: each stage subtracts its own previous input when a token arrives.
  always_ff @(posedge PDMCLK) begin
    if (RST) begin
      for (int k = 0; k < N; k++) begin
        comb_r[k] <= '0;
        dly_r[k]  <= '0;
      end
      comb_vld_r <= '0;
    end else begin
      comb_vld_r <= {comb_vld_r[N-2:0], comb_in_vld_r};
      if (comb_in_vld_r) begin
        comb_r[0] <= comb_in_r - dly_r[0];
        dly_r[0]  <= comb_in_r;
      end
      for (int k = 1; k < N; k++) begin
        if (comb_vld_r[k-1]) begin
          comb_r[k] <= comb_r[k-1] - dly_r[k];
          dly_r[k]  <= comb_r[k-1];
        end
      end
    end
  end

  // Scale the last comb stage to 17 bits and clamp to the signed range.
  always_comb begin
    scaled_s = YW'(comb_r[N-1]) >>> SHIFT;
    y_s      = scaled_s[16:0];
    clamp_s  = 1'b0;
    if (scaled_s > POS_LIM) begin
      y_s     = 17'sh0FFFF;
      clamp_s = 1'b1;
    end else if (scaled_s < NEG_LIM) begin
      y_s     = 17'sh10000;
      clamp_s = 1'b1;
    end else begin
      y_s     = scaled_s[16:0];
      clamp_s = 1'b0;
    end
  end

  // Output register: loads only when a token leaves the last comb stage.
  always_ff @(posedge PDMCLK) begin
    if (RST) begin
      out_r   <= '0;
      valid_r <= 1'b0;
      sat_r   <= 1'b0;
    end else begin
      valid_r <= comb_vld_r[N-1];
      sat_r   <= comb_vld_r[N-1] & clamp_s;
      if (comb_vld_r[N-1]) begin
        out_r <= y_s;
      end
    end
  end

  assign bus.cic_out   = out_r;
  assign bus.cic_valid = valid_r;
  assign bus.cic_sat   = sat_r;

endmodule

// File: tb/tb_pdm_cic_decimator.sv
// -----------------------------------------------------------------------------
// tb_pdm_cic_decimator
// Drives randomized strobe spacing and PDM data into a default instance
// (DEC_LOG2 = 5) and a small instance (DEC_LOG2 = 3). The reference model is a
// direct FIR: each output is the input history convolved with four cascaded
// length-R boxcars (delayed by 3 samples from the integrator chain), scaled and
// clamped, expected exactly 5 cycles after the capturing edge.
// -----------------------------------------------------------------------------
module tb_pdm_cic_decimator;

  typedef struct packed {
    logic [31:0] stamp;
    logic [31:0] y;
    logic        sat;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pdm_cic_decimator_if bus_a ();
  pdm_cic_decimator_if bus_b ();

  pdm_cic_decimator #(.DEC_LOG2(5)) dut_a (.PDMCLK(clk), .RST(rst), .bus(bus_a.slave));
  pdm_cic_decimator #(.DEC_LOG2(3)) dut_b (.PDMCLK(clk), .RST(rst), .bus(bus_b.slave));

  int  tests_run = 0;
  int  tests_failed = 0;
  int  cyc = 0;
  bit  rst_q = 1'b1;
  int  proto_err = 0;
  int  h_a[];
  int  h_b[];
  int  hist_a[$];
  int  hist_b[$];
  ev_t exp_a[$], obs_a[$], exp_b[$], obs_b[$];
  logic [16:0] prev_a = '0;
  logic [16:0] prev_b = '0;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  // Record every valid pulse and flag outputs that move without a pulse.
  always @(negedge clk) begin
    ev_t o;
    if (bus_a.cic_valid === 1'b1) begin
      o.stamp = 32'(cyc); o.y = 32'($signed(bus_a.cic_out)); o.sat = bus_a.cic_sat;
      obs_a.push_back(o);
    end
    if (bus_b.cic_valid === 1'b1) begin
      o.stamp = 32'(cyc); o.y = 32'($signed(bus_b.cic_out)); o.sat = bus_b.cic_sat;
      obs_b.push_back(o);
    end
    if (!rst_q) begin
      if (bus_a.cic_valid !== 1'b1 && bus_a.cic_out !== prev_a) proto_err++;
      if (bus_b.cic_valid !== 1'b1 && bus_b.cic_out !== prev_b) proto_err++;
      if (bus_a.cic_sat === 1'b1 && bus_a.cic_valid !== 1'b1) proto_err++;
      if (bus_b.cic_sat === 1'b1 && bus_b.cic_valid !== 1'b1) proto_err++;
    end
    prev_a = bus_a.cic_out;
    prev_b = bus_b.cic_out;
  end

  // Impulse response of four cascaded boxcars: number of ways to write j as a sum of four values in 0..r-1.
  function automatic void build_h(input int r, output int h[]);
    h = new[4*r-3];
    foreach (h[i]) h[i] = 0;
    for (int a = 0; a < r; a++)
      for (int b = 0; b < r; b++)
        for (int c = 0; c < r; c++)
          for (int d = 0; d < r; d++)
            h[a+b+c+d] += 1;
  endfunction

  function automatic void ref_y(input bit sel, input int n, output int y, output bit s);
    int l, acc, sh, idx, taps;
    l    = sel ? 3 : 5;
    taps = sel ? h_b.size() : h_a.size();
    acc  = 0;
    for (int j = 0; j < taps; j++) begin
      idx = n - 3 - j;
      if (idx >= 0) begin
        if (sel) acc += h_b[j] * hist_b[idx];
        else     acc += h_a[j] * hist_a[idx];
      end
    end
    sh = 4*l + 1 - 17;
    if (sh < 0) sh = 0;
    acc = acc >>> sh;
    s = 1'b0;
    if (acc > 65535) begin acc = 65535; s = 1'b1; end
    else if (acc < -65536) begin acc = -65536; s = 1'b1; end
    y = acc;
  endfunction

  // One PDM strobe on instance sel, then gap-1 idle cycles; queues the expected output on every R-th strobe.
  task automatic strobe(input bit sel, input bit b, input int gap);
    ev_t e;
    int  y;
    bit  s;
    if (sel) begin bus_b.pdm_in = b; bus_b.PDM_EN = 1'b1; end
    else     begin bus_a.pdm_in = b; bus_a.PDM_EN = 1'b1; end
    @(posedge clk); #1;
    bus_a.PDM_EN = 1'b0;
    bus_b.PDM_EN = 1'b0;
    if (sel) begin
      hist_b.push_back(b ? 1 : -1);
      if (hist_b.size() % 8 == 0) begin
        ref_y(1'b1, hist_b.size() - 1, y, s);
        e.stamp = 32'(cyc + 5); e.y = 32'(y); e.sat = s;
        exp_b.push_back(e);
      end
    end else begin
      hist_a.push_back(b ? 1 : -1);
      if (hist_a.size() % 32 == 0) begin
        ref_y(1'b0, hist_a.size() - 1, y, s);
        e.stamp = 32'(cyc + 5); e.y = 32'(y); e.sat = s;
        exp_a.push_back(e);
      end
    end
    repeat (gap - 1) @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) begin
      bus_a.PDM_EN = 1'($urandom); bus_a.pdm_in = 1'($urandom);
      bus_b.PDM_EN = 1'($urandom); bus_b.pdm_in = 1'($urandom);
      @(posedge clk); #1;
    end
    bus_a.PDM_EN = 1'b0;
    bus_b.PDM_EN = 1'b0;
    rst = 1'b0;
    hist_a.delete(); hist_b.delete();
    exp_a.delete(); obs_a.delete(); exp_b.delete(); obs_b.delete();
  endtask

  task automatic test_reset();
    ev_t e, o;
    apply_reset(3);
    tests_run++;
    if (bus_a.cic_out !== 17'sd0) begin tests_failed++; $display("FAIL reset_out: got %0d, expected 0", $signed(bus_a.cic_out)); end
    tests_run++;
    if (bus_a.cic_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b, expected 0", bus_a.cic_valid); end
    tests_run++;
    if (bus_a.cic_sat !== 1'b0) begin tests_failed++; $display("FAIL reset_sat: got %b, expected 0", bus_a.cic_sat); end
    for (int i = 0; i < 31; i++) strobe(1'b0, 1'($urandom), $urandom_range(6, 9));
    repeat (8) @(posedge clk); #1;
    tests_run++;
    if (obs_a.size() !== 0) begin tests_failed++; $display("FAIL reset_early_valid: got %0d pulses before strobe 32, expected 0", obs_a.size()); end
    strobe(1'b0, 1'($urandom), 6);
    repeat (8) @(posedge clk); #1;
    tests_run++;
    if (obs_a.size() !== 1) begin tests_failed++; $display("FAIL reset_first_count: got %0d pulses, expected 1", obs_a.size()); end
    if (obs_a.size() > 0 && exp_a.size() > 0) begin
      e = exp_a.pop_front(); o = obs_a.pop_front();
      tests_run++;
      if (o !== e) begin
        tests_failed++;
        $display("FAIL reset_first_out: got cyc=%0d y=%0d sat=%0b, expected cyc=%0d y=%0d sat=%0b",
                 o.stamp, $signed(o.y), o.sat, e.stamp, $signed(e.y), e.sat);
      end
    end
    exp_a.delete(); obs_a.delete();
  endtask

  // Constant/periodic pattern on the default instance; steady value from the 6th output on.
  task automatic test_steady(input string name, input logic [3:0] pat, input int steady, input int outputs);
    ev_t e, o;
    int  k;
    apply_reset(3);
    for (int i = 0; i < outputs * 32; i++) strobe(1'b0, pat[i % 4], $urandom_range(6, 9));
    repeat (8) @(posedge clk); #1;
    tests_run++;
    if (obs_a.size() !== exp_a.size()) begin
      tests_failed++; $display("FAIL %s count: got %0d outputs, expected %0d", name, obs_a.size(), exp_a.size());
    end
    k = 0;
    while (exp_a.size() > 0 && obs_a.size() > 0) begin
      e = exp_a.pop_front(); o = obs_a.pop_front(); k++;
      tests_run++;
      if (o !== e) begin
        tests_failed++;
        $display("FAIL %s out%0d: got cyc=%0d y=%0d sat=%0b, expected cyc=%0d y=%0d sat=%0b",
                 name, k, o.stamp, $signed(o.y), o.sat, e.stamp, $signed(e.y), e.sat);
      end
      if (k >= 6) begin
        tests_run++;
        if (o.y !== 32'(steady) || o.sat !== (steady == 65535)) begin
          tests_failed++;
          $display("FAIL %s steady%0d: got y=%0d sat=%0b, expected y=%0d sat=%0b",
                   name, k, $signed(o.y), o.sat, steady, (steady == 65535));
        end
      end
    end
    exp_a.delete(); obs_a.delete();
  endtask

  // Long all-ones run wraps the integrators many times, then the input flips to alternating.
  task automatic test_wrap();
    ev_t e, o;
    int  k;
    logic [31:0] last_y;
    apply_reset(3);
    for (int i = 0; i < 2048; i++) strobe(1'b0, 1'b1, $urandom_range(6, 8));
    repeat (8) @(posedge clk); #1;
    k = 0;
    while (exp_a.size() > 0 && obs_a.size() > 0) begin
      e = exp_a.pop_front(); o = obs_a.pop_front(); k++;
      tests_run++;
      if (o !== e || (k >= 6 && o.y !== 32'(65535))) begin
        tests_failed++;
        $display("FAIL wrap_ones out%0d: got cyc=%0d y=%0d sat=%0b, expected cyc=%0d y=%0d sat=%0b",
                 k, o.stamp, $signed(o.y), o.sat, e.stamp, $signed(e.y), e.sat);
      end
    end
    tests_run++;
    if (k !== 64 || obs_a.size() !== 0) begin tests_failed++; $display("FAIL wrap_ones_count: got %0d outputs, expected 64", k + obs_a.size()); end
    exp_a.delete(); obs_a.delete();
    for (int i = 0; i < 6 * 32; i++) strobe(1'b0, (i % 2 == 0), $urandom_range(6, 8));
    repeat (8) @(posedge clk); #1;
    k = 0;
    last_y = 32'hDEAD_BEEF;
    while (exp_a.size() > 0 && obs_a.size() > 0) begin
      e = exp_a.pop_front(); o = obs_a.pop_front(); k++;
      last_y = o.y;
      tests_run++;
      if (o !== e) begin
        tests_failed++;
        $display("FAIL wrap_alt out%0d: got cyc=%0d y=%0d sat=%0b, expected cyc=%0d y=%0d sat=%0b",
                 k, o.stamp, $signed(o.y), o.sat, e.stamp, $signed(e.y), e.sat);
      end
    end
    tests_run++;
    if (k !== 6 || last_y !== 32'd0) begin tests_failed++; $display("FAIL wrap_settle: got %0d outputs ending at %0d, expected 6 ending at 0", k, $signed(last_y)); end
    exp_a.delete(); obs_a.delete();
  endtask

  // Reset lands while a token is inside the comb pipeline; afterwards behaviour matches a fresh start.
  task automatic test_reset_mid_pipeline();
    ev_t e, o;
    int  k;
    apply_reset(3);
    for (int i = 0; i < 31; i++) strobe(1'b0, 1'b1, $urandom_range(6, 8));
    strobe(1'b0, 1'b1, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    hist_a.delete(); exp_a.delete(); obs_a.delete();
    repeat (12) @(posedge clk); #1;
    tests_run++;
    if (obs_a.size() !== 0) begin tests_failed++; $display("FAIL mid_reset_aborted: got %0d pulses, expected 0", obs_a.size()); end
    tests_run++;
    if (bus_a.cic_out !== 17'sd0) begin tests_failed++; $display("FAIL mid_reset_out: got %0d, expected 0", $signed(bus_a.cic_out)); end
    obs_a.delete();
    for (int i = 0; i < 7 * 32; i++) strobe(1'b0, 1'b1, $urandom_range(6, 9));
    repeat (8) @(posedge clk); #1;
    k = 0;
    while (exp_a.size() > 0 && obs_a.size() > 0) begin
      e = exp_a.pop_front(); o = obs_a.pop_front(); k++;
      tests_run++;
      if (o !== e) begin
        tests_failed++;
        $display("FAIL mid_reset out%0d: got cyc=%0d y=%0d sat=%0b, expected cyc=%0d y=%0d sat=%0b",
                 k, o.stamp, $signed(o.y), o.sat, e.stamp, $signed(e.y), e.sat);
      end
    end
    tests_run++;
    if (k !== 7) begin tests_failed++; $display("FAIL mid_reset_count: got %0d outputs, expected 7", k); end
    exp_a.delete(); obs_a.delete();
  endtask

  // DEC_LOG2 = 3: R^4 = 4096 passes through unscaled and unclamped; the idle default instance stays silent.
  task automatic test_param_sweep();
    ev_t e, o;
    int  k;
    apply_reset(3);
    for (int i = 0; i < 8 * 8; i++) strobe(1'b1, 1'b1, $urandom_range(6, 9));
    repeat (8) @(posedge clk); #1;
    k = 0;
    while (exp_b.size() > 0 && obs_b.size() > 0) begin
      e = exp_b.pop_front(); o = obs_b.pop_front(); k++;
      tests_run++;
      if (o !== e || (k >= 6 && (o.y !== 32'd4096 || o.sat !== 1'b0))) begin
        tests_failed++;
        $display("FAIL sweep out%0d: got cyc=%0d y=%0d sat=%0b, expected cyc=%0d y=%0d sat=%0b",
                 k, o.stamp, $signed(o.y), o.sat, e.stamp, $signed(e.y), e.sat);
      end
    end
    tests_run++;
    if (k !== 8) begin tests_failed++; $display("FAIL sweep_count: got %0d outputs, expected 8", k); end
    tests_run++;
    if (obs_a.size() !== 0) begin tests_failed++; $display("FAIL idle_no_valid: got %0d pulses, expected 0", obs_a.size()); end
    exp_b.delete(); obs_b.delete();
  endtask

  task automatic test_output_protocol();
    tests_run++;
    if (proto_err !== 0) begin tests_failed++; $display("FAIL output_hold: got %0d hold/sat violations, expected 0", proto_err); end
  endtask

  initial begin
    bus_a.PDM_EN = 1'b0; bus_a.pdm_in = 1'b0;
    bus_b.PDM_EN = 1'b0; bus_b.pdm_in = 1'b0;
    build_h(32, h_a);
    build_h(8, h_b);
    apply_reset(2);
    // Leave non-zero state behind so the reset test has something to clear.
    for (int i = 0; i < 40; i++) strobe(1'b0, 1'($urandom), 6);
    strobe(1'b0, 1'b1, 3);
    test_reset();
    test_steady("all_ones",    4'b1111,  65535, 10);
    test_steady("all_zeros",   4'b0000, -65536, 10);
    test_steady("alternating", 4'b0101,      0,  8);
    test_steady("biased_1110", 4'b0111,  32768,  8);
    test_wrap();
    test_reset_mid_pipeline();
    test_param_sweep();
    test_output_protocol();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
